sumcheck_round_verifier: RTL and testbench
==========================================

SUMCHECK_ROUND_VERIFIER -- requirements
Module: sumcheck_round_verifier

Interface
REQ-001 SHALL have parameter UINT_WIDTH, default 32: field element width.
REQ-002 SHALL have parameter NUM_ROUNDS, default 4: sumcheck rounds per proof (>=1).
REQ-003 SHALL have parameter PRIME, default 32'hFFFFFFFB: field modulus; 2^(UINT_WIDTH-1) < PRIME < 2^UINT_WIDTH.
REQ-004 Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin proof; sampled in IDLE or DONE.
- claim_in  in  UINT_WIDTH  initial claimed sum, captured with start.
- sample_valid  in  1  prover round message valid.
- sample_ready  out  1  verifier accepts round message.
- sample_pts  in  3 x UINT_WIDTH  g_j(0), g_j(1), g_j(2).
- random  in  1  serial random bit, MSB first.
- r_valid  out  1  one-cycle pulse: challenge r_j final.
- r_out  out  UINT_WIDTH  challenge r_j.
- round_idx  out  $clog2(NUM_ROUNDS+1)  current round j.
- final_valid  in  1  oracle evaluation valid.
- final_ready  out  1  verifier accepts oracle evaluation.
- final_eval  in  UINT_WIDTH  oracle value at (r_1..r_n).
- busy  out  1  high outside IDLE and DONE.
- done  out  1  high while in DONE.
- accept  out  1  verdict; valid when done=1.

Function
REQ-005 SHALL implement FSM IDLE -> RECV -> CHECK -> RAND -> EVAL -> (RECV | FINAL) -> DONE.
REQ-006 IDLE/DONE: start=1 SHALL load claim_in, round_idx=0, accept=1, enter RECV next cycle.
REQ-007 RECV: sample_ready=1; on sample_valid&sample_ready SHALL register sample_pts and enter CHECK; data held by prover until handshake.
REQ-008 CHECK (1 cycle): SHALL clear accept if any sample >= PRIME or (s0+s1) mod PRIME != claim; sum computed UINT_WIDTH+1 bits wide.
REQ-009 RAND: SHALL shift in exactly UINT_WIDTH random bits, one per cycle, MSB first; then r = acc, or acc-PRIME if acc >= PRIME.
REQ-010 r_valid SHALL pulse in the cycle r_out first holds the reduced r; r_out holds until next RAND completes.
REQ-011 EVAL: SHALL compute claim <= g_j(r) mod PRIME by Lagrange on x=0,1,2 using inv2=(PRIME+1)/2, one modular multiply per cycle, fixed 4 cycles.
REQ-012 After EVAL: round_idx increments; round_idx==NUM_ROUNDS SHALL enter FINAL, else RECV.
REQ-013 FINAL: final_ready=1; on handshake SHALL clear accept if final_eval != claim; enter DONE.
REQ-014 accept SHALL only transition 1->0 within a proof; never re-set except by start.
REQ-015 start outside IDLE/DONE SHALL be ignored; sample_valid outside RECV and final_valid outside FINAL SHALL be ignored.

Reset
REQ-016 rst SHALL force IDLE, round_idx=0, accept=1, r_valid=0, r_out=0, busy=0, done=0, sample_ready=0, final_ready=0, from any state, mid-proof included; rst wins over start.

Configuration
REQ-017 Macro SUMCHECK_EARLY_ABORT_EN: defined -> failed CHECK SHALL go directly to DONE (no RAND/EVAL, no r_valid); undefined -> all rounds and FINAL run with accept latched 0.

Structure
REQ-018 Package sumcheck_pkg SHALL hold the FSM state enum and modular add/sub/mul functions.
REQ-019 Sub-module mod_mul (registered modular multiply, 1-cycle latency) SHALL be instantiated once in EVAL.

Verification (PRIME=97, UINT_WIDTH=7, NUM_ROUNDS=2)
REQ-020 claim 10, round1 (3,7,13), random 7 ones -> r_out=30, r_valid 1 pulse, claim becomes 23.
REQ-021 Honest 2-round proof, final_eval equals final claim -> done=1, accept=1.
REQ-022 claim 10, round1 (3,8,0) -> accept=0; macro on: DONE without r_valid; off: DONE after 2 rounds+FINAL.
REQ-023 Sample 97 in round 1 with valid sum -> accept=0.
REQ-024 rst asserted in EVAL of round 1 -> next cycle IDLE, all outputs at reset values; new start completes normally.
REQ-025 sample_valid low 5 cycles in RECV, random bits all 0 -> FSM waits, r=0, claim becomes s0.

Source files
------------

// File: rtl/sumcheck_pkg.sv
// Shared FSM encoding, control-output decode and modular arithmetic helpers for the sumcheck verifier.
// Helpers use 64-bit containers, so field widths up to 32 bits keep a*b exact before reduction.
package sumcheck_pkg;

    localparam int FELEM_W = 64;
    typedef logic [FELEM_W-1:0] felem_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_CHECK = 3'd2,
        S_RAND  = 3'd3,
        S_EVAL  = 3'd4,
        S_FINAL = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    typedef struct packed {
        logic busy;
        logic done;
        logic sample_ready;
        logic final_ready;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c.busy         = (s != S_IDLE) && (s != S_DONE);
        c.done         = (s == S_DONE);
        c.sample_ready = (s == S_RECV);
        c.final_ready  = (s == S_FINAL);
        return c;
    endfunction

    function automatic felem_t fmod_add(input felem_t a, input felem_t b, input felem_t p);
        felem_t s;
        s = a + b;
        return (s >= p) ? s - p : s;
    endfunction

    function automatic felem_t fmod_sub(input felem_t a, input felem_t b, input felem_t p);
        return (a >= b) ? a - b : a + p - b;
    endfunction

    function automatic felem_t fmod_mul(input felem_t a, input felem_t b, input felem_t p);
        return (a * b) % p;
    endfunction

endpackage

// File: rtl/sumcheck_round_verifier_mod_mul.sv
// mod_mul: registered modular multiply, result valid one cycle after the operands.
module mod_mul
    import sumcheck_pkg::*;
#(
    parameter int                    UINT_WIDTH = 32,
    parameter logic [UINT_WIDTH-1:0] PRIME      = 32'hFFFFFFFB
) (
    input  logic                  clk,
    input  logic [UINT_WIDTH-1:0] a_i,
    input  logic [UINT_WIDTH-1:0] b_i,
    output logic [UINT_WIDTH-1:0] p_o
);

    logic [UINT_WIDTH-1:0] p_q;

    always_ff @(posedge clk) begin
        p_q <= UINT_WIDTH'(fmod_mul(felem_t'(a_i), felem_t'(b_i), felem_t'(PRIME)));
    end

    assign p_o = p_q;

endmodule

// File: rtl/sumcheck_round_verifier.sv
// Sumcheck round verifier over GF(PRIME): checks each round message, draws a serial challenge, folds the claim.
// Define SUMCHECK_EARLY_ABORT_EN to go straight to DONE when a round check fails.
module sumcheck_round_verifier
    import sumcheck_pkg::*;
#(
    parameter int                    UINT_WIDTH = 32,
    parameter int                    NUM_ROUNDS = 4,
    parameter logic [UINT_WIDTH-1:0] PRIME      = 32'hFFFFFFFB
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [UINT_WIDTH-1:0]               claim_in,
    input  logic                                sample_valid,
    output logic                                sample_ready,
    input  logic [2:0][UINT_WIDTH-1:0]          sample_pts,
    input  logic                                random,
    output logic                                r_valid,
    output logic [UINT_WIDTH-1:0]               r_out,
    output logic [$clog2(NUM_ROUNDS+1)-1:0]     round_idx,
    input  logic                                final_valid,
    output logic                                final_ready,
    input  logic [UINT_WIDTH-1:0]               final_eval,
    output logic                                busy,
    output logic                                done,
    output logic                                accept
);

    localparam int RIDX_W = $clog2(NUM_ROUNDS + 1);
    localparam int BCNT_W = $clog2(UINT_WIDTH + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT   = BCNT_W'(UINT_WIDTH - 1);
    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NUM_ROUNDS - 1);
    localparam felem_t P_F  = felem_t'(PRIME);
    localparam felem_t INV2 = (P_F + 64'd1) >> 1;

    state_e                      state_q;
    ctrl_t                       ctrl_q;
    logic [UINT_WIDTH-1:0]       claim_q;
    logic [UINT_WIDTH-1:0]       r_out_q;
    logic [UINT_WIDTH-2:0]       acc_q;
    logic [2:0][UINT_WIDTH-1:0]  pts_q;
    logic [RIDX_W-1:0]           round_idx_q;
    logic [BCNT_W-1:0]           bit_cnt_q;
    logic [1:0]                  step_q;
    logic                        accept_q;
    logic                        r_valid_q;

    // Round check: every sample must be canonical and g(0)+g(1) must match the running claim.
    logic [2:0]            in_range;
    logic [UINT_WIDTH:0]   sum_raw;
    logic [UINT_WIDTH:0]   sum_red;
    logic                  check_ok;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_range
            assign in_range[gi] = (pts_q[gi] < PRIME);
        end
    endgenerate

    assign sum_raw  = {1'b0, pts_q[0]} + {1'b0, pts_q[1]};
    assign sum_red  = (sum_raw >= {1'b0, PRIME}) ? sum_raw - {1'b0, PRIME} : sum_raw;
    assign check_ok = (&in_range) && (sum_red == {1'b0, claim_q});

    // Challenge: the top bit only ever lives in acc_d, so one subtraction reduces it (acc < 2*PRIME).
    logic [UINT_WIDTH-1:0] acc_d;
    logic [UINT_WIDTH-1:0] r_d;

    assign acc_d = {acc_q, random};
    assign r_d   = (acc_d >= PRIME) ? acc_d - PRIME : acc_d;

    // g(r) = g0 + r*(d1 + (r-1)*c2), c2 = (g2 - 2*g1 + g0)*inv2: three chained multiplies in four cycles.
    felem_t g0_f, g1_f, g2_f, r_f, prod_f, d1_f, dd_f;
    logic [UINT_WIDTH-1:0] mul_a, mul_b, mul_p;
    logic [UINT_WIDTH-1:0] claim_d;

    assign g0_f   = felem_t'(pts_q[0]);
    assign g1_f   = felem_t'(pts_q[1]);
    assign g2_f   = felem_t'(pts_q[2]);
    assign r_f    = felem_t'(r_out_q);
    assign prod_f = felem_t'(mul_p);
    assign d1_f   = fmod_sub(g1_f, g0_f, P_F);
    assign dd_f   = fmod_add(fmod_sub(g2_f, g1_f, P_F), fmod_sub(g0_f, g1_f, P_F), P_F);

    always_comb begin
        mul_a = UINT_WIDTH'(dd_f);
        mul_b = UINT_WIDTH'(INV2);
        case (step_q)
            2'd1: begin
                mul_a = UINT_WIDTH'(fmod_sub(r_f, 64'd1, P_F));
                mul_b = mul_p;
            end
            2'd2: begin
                mul_a = r_out_q;
                mul_b = UINT_WIDTH'(fmod_add(d1_f, prod_f, P_F));
            end
            default: ;
        endcase
    end

    assign claim_d = UINT_WIDTH'(fmod_add(g0_f, prod_f, P_F));

    mod_mul #(
        .UINT_WIDTH(UINT_WIDTH),
        .PRIME     (PRIME)
    ) u_mod_mul (
        .clk(clk),
        .a_i(mul_a),
        .b_i(mul_b),
        .p_o(mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ctrl_q      <= state_ctrl(S_IDLE);
            claim_q     <= '0;
            r_out_q     <= '0;
            acc_q       <= '0;
            pts_q       <= '0;
            round_idx_q <= '0;
            bit_cnt_q   <= '0;
            step_q      <= '0;
            accept_q    <= 1'b1;
            r_valid_q   <= 1'b0;
        end else begin
            r_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        claim_q     <= claim_in;
                        round_idx_q <= '0;
                        accept_q    <= 1'b1;
                        state_q     <= S_RECV;
                        ctrl_q      <= state_ctrl(S_RECV);
                    end
                end
                S_RECV: begin
                    if (sample_valid && ctrl_q.sample_ready) begin
                        pts_q   <= sample_pts;
                        state_q <= S_CHECK;
                        ctrl_q  <= state_ctrl(S_CHECK);
                    end
                end
                S_CHECK: begin
                    acc_q     <= '0;
                    bit_cnt_q <= '0;
                    if (!check_ok) begin
                        accept_q <= 1'b0;
                    end
`ifdef SUMCHECK_EARLY_ABORT_EN
                    if (!check_ok) begin
                        state_q <= S_DONE;
                        ctrl_q  <= state_ctrl(S_DONE);
                    end else begin
                        state_q <= S_RAND;
                        ctrl_q  <= state_ctrl(S_RAND);
                    end
`else
                    state_q <= S_RAND;
                    ctrl_q  <= state_ctrl(S_RAND);
`endif
                end
                S_RAND: begin
                    acc_q     <= acc_d[UINT_WIDTH-2:0];
                    bit_cnt_q <= bit_cnt_q + BCNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        r_out_q   <= r_d;
                        r_valid_q <= 1'b1;
                        step_q    <= '0;
                        state_q   <= S_EVAL;
                        ctrl_q    <= state_ctrl(S_EVAL);
                    end
                end
                S_EVAL: begin
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        claim_q     <= claim_d;
                        round_idx_q <= round_idx_q + RIDX_W'(1);
                        if (round_idx_q == LAST_ROUND) begin
                            state_q <= S_FINAL;
                            ctrl_q  <= state_ctrl(S_FINAL);
                        end else begin
                            state_q <= S_RECV;
                            ctrl_q  <= state_ctrl(S_RECV);
                        end
                    end
                end
                S_FINAL: begin
                    if (final_valid && ctrl_q.final_ready) begin
                        if (final_eval != claim_q) begin
                            accept_q <= 1'b0;
                        end
                        state_q <= S_DONE;
                        ctrl_q  <= state_ctrl(S_DONE);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ctrl_q  <= state_ctrl(S_IDLE);
                end
            endcase
        end
    end

    assign sample_ready = ctrl_q.sample_ready;
    assign final_ready  = ctrl_q.final_ready;
    assign busy         = ctrl_q.busy;
    assign done         = ctrl_q.done;
    assign accept       = accept_q;
    assign r_valid      = r_valid_q;
    assign r_out        = r_out_q;
    assign round_idx    = round_idx_q;

endmodule

// File: tb/tb_sumcheck_round_verifier.sv
// Scoreboard bench for sumcheck_round_verifier with PRIME=97, UINT_WIDTH=7, NUM_ROUNDS=2.
// Expectations follow SUMCHECK_EARLY_ABORT_EN when the bench is built with that macro.
module tb_sumcheck_round_verifier;

    localparam int W  = 7;
    localparam int NR = 2;
    localparam int P  = 97;
`ifdef SUMCHECK_EARLY_ABORT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     claim_in = '0;
    logic             sample_valid = 1'b0;
    logic             sample_ready;
    logic [2:0][W-1:0] sample_pts = '0;
    logic             random = 1'b0;
    logic             r_valid;
    logic [W-1:0]     r_out;
    logic [1:0]       round_idx;
    logic             final_valid = 1'b0;
    logic             final_ready;
    logic [W-1:0]     final_eval = '0;
    logic             busy;
    logic             done;
    logic             accept;

    always #5 clk = ~clk;

    sumcheck_round_verifier #(
        .UINT_WIDTH(W),
        .NUM_ROUNDS(NR),
        .PRIME     (7'd97)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .claim_in    (claim_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_pts  (sample_pts),
        .random      (random),
        .r_valid     (r_valid),
        .r_out       (r_out),
        .round_idx   (round_idx),
        .final_valid (final_valid),
        .final_ready (final_ready),
        .final_eval  (final_eval),
        .busy        (busy),
        .done        (done),
        .accept      (accept)
    );

    typedef struct {
        int r;
        int ridx;
    } rexp_t;

    rexp_t exp_r_q[$];
    int    exp_v_q[$];
    int    checks   = 0;
    int    failures = 0;

    int st_g[NR][3];
    bit st_hon[NR];
    int st_bits[NR];
    int st_dly[NR];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int modp(input longint x);
        longint m;
        m = x % P;
        if (m < 0) m += P;
        return int'(m);
    endfunction

    // Lagrange interpolation through x=0,1,2; the numerators of the 1/2 terms are always even.
    function automatic int lag(input int g0, input int g1, input int g2, input int r);
        longint rr;
        rr = r;
        return modp(g0 * (rr - 1) * (rr - 2) / 2 - g1 * rr * (rr - 2) + g2 * rr * (rr - 1) / 2);
    endfunction

    task automatic set_round(input int j, input int g0, input int g1, input int g2,
                             input bit hon, input int bits, input int dly);
        st_g[j][0] = g0;
        st_g[j][1] = g1;
        st_g[j][2] = g2;
        st_hon[j]  = hon;
        st_bits[j] = bits;
        st_dly[j]  = dly;
    endtask

    task automatic wait_for(input int which, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            case (which)
                0:       seen = sample_ready;
                1:       seen = final_ready;
                default: seen = done;
            endcase
            n++;
        end
        chk(name, seen, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sample_ready"}, sample_ready, 0);
        chk({tag, "_final_ready"}, final_ready, 0);
        chk({tag, "_r_valid"}, r_valid, 0);
        chk({tag, "_r_out"}, r_out, 0);
        chk({tag, "_round_idx"}, round_idx, 0);
        chk({tag, "_accept"}, accept, 1);
    endtask

    task automatic run_proof(input int claim0, input bit fin_bad, input bit rst_eval);
        int claim, g0, g1, g2, r, fe;
        bit ok, rnd_ok;
        claim = claim0;
        ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        claim_in = W'(claim0);
        @(posedge clk);
        #1;
        start = 1'b0;
        claim_in = W'($urandom);
        for (int j = 0; j < NR; j++) begin
            g0 = st_g[j][0];
            g2 = st_g[j][2];
            g1 = st_hon[j] ? modp(claim - g0) : st_g[j][1];
            rnd_ok = (g0 < P) && (g1 < P) && (g2 < P) && (((g0 + g1) % P) == claim);
            if (!rnd_ok) ok = 1'b0;
            wait_for(0, "sample_ready_timeout");
            repeat (st_dly[j]) begin
                sample_pts = (3 * W)'($urandom);
                @(negedge clk);
            end
            sample_valid = 1'b1;
            sample_pts[0] = W'(g0);
            sample_pts[1] = W'(g1);
            sample_pts[2] = W'(g2);
            @(posedge clk);
            #1;
            sample_valid = 1'b0;
            if (EARLY && !rnd_ok) begin
                exp_v_q.push_back(0);
                wait_for(2, "done_timeout");
                return;
            end
            r = st_bits[j] % P;
            exp_r_q.push_back('{r, j});
            @(negedge clk);
            random = 1'($urandom);
            start = 1'b1;
            claim_in = W'($urandom);
            sample_valid = 1'b1;
            final_valid = 1'b1;
            final_eval = W'($urandom);
            for (int k = W - 1; k >= 0; k--) begin
                @(negedge clk);
                random = st_bits[j][k];
            end
            @(negedge clk);
            start = 1'b0;
            sample_valid = 1'b0;
            final_valid = 1'b0;
            random = 1'b0;
            if (rst_eval) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check_reset("rst_in_eval");
                rst = 1'b0;
                return;
            end
            claim = lag(g0, g1, g2, r);
        end
        wait_for(1, "final_ready_timeout");
        fe = fin_bad ? modp(claim + 1) : claim;
        if (fe != claim) ok = 1'b0;
        exp_v_q.push_back(ok ? 1 : 0);
        final_valid = 1'b1;
        final_eval = W'(fe);
        @(posedge clk);
        #1;
        final_valid = 1'b0;
        wait_for(2, "done_timeout");
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a challenge or a verdict.
    bit    r_valid_prev = 1'b0;
    bit    done_prev    = 1'b0;
    rexp_t e_r;
    int    e_v;
    always @(negedge clk) begin
        if (r_valid === 1'b1) begin
            chk("r_valid_pulse_width", r_valid_prev, 0);
            chk("r_valid_expected", exp_r_q.size() > 0, 1);
            if (exp_r_q.size() > 0) begin
                e_r = exp_r_q.pop_front();
                $display("challenge round=%0d r_out=%0d expected=%0d", e_r.ridx, r_out, e_r.r);
                chk("r_out", r_out, e_r.r);
                chk("round_idx_at_r_valid", round_idx, e_r.ridx);
            end
        end
        if (done === 1'b1 && !done_prev) begin
            chk("verdict_expected", exp_v_q.size() > 0, 1);
            if (exp_v_q.size() > 0) begin
                e_v = exp_v_q.pop_front();
                $display("verdict accept=%0d expected=%0d", accept, e_v);
                chk("accept", accept, e_v);
                chk("busy_in_done", busy, 0);
            end
        end
        r_valid_prev <= (r_valid === 1'b1);
        done_prev    <= (done === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b1;
        claim_in = 7'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        start = 1'b0;
        rst = 1'b0;

        // claim 10, (3,7,13), all-ones challenge -> r=30, claim folds to 23
        set_round(0, 3, 7, 13, 1'b0, 127, 0);
        set_round(1, 5, 0, 40, 1'b1, 77, 1);
        run_proof(10, 1'b0, 1'b0);

        // stalled prover and zero challenge -> claim becomes s0; then r=96 boundary
        set_round(0, 12, 8, 50, 1'b0, 0, 5);
        set_round(1, 30, 0, 2, 1'b1, 96, 0);
        run_proof(20, 1'b0, 1'b0);

        // wrong round-1 sum
        set_round(0, 3, 8, 0, 1'b0, 5, 0);
        set_round(1, 1, 1, 1, 1'b0, 10, 0);
        run_proof(10, 1'b0, 1'b0);

        // non-canonical sample with a valid modular sum; challenge 97 reduces to 0
        set_round(0, 97, 10, 5, 1'b0, 97, 0);
        set_round(1, 4, 0, 9, 1'b1, 33, 0);
        run_proof(10, 1'b0, 1'b0);

        // reset during EVAL, then a fresh proof must complete
        set_round(0, 4, 6, 9, 1'b0, 50, 0);
        run_proof(10, 1'b0, 1'b1);
        set_round(0, 60, 0, 96, 1'b1, 126, 2);
        set_round(1, 0, 0, 0, 1'b1, 1, 0);
        run_proof(90, 1'b0, 1'b0);

        // honest rounds, wrong oracle value
        set_round(0, 11, 0, 22, 1'b1, 64, 0);
        set_round(1, 33, 0, 44, 1'b1, 100, 0);
        run_proof(50, 1'b1, 1'b0);

        for (int t = 0; t < 25; t++) begin
            for (int j = 0; j < NR; j++) begin
                set_round(j, $urandom_range(0, P - 1), $urandom_range(0, P - 1),
                          ($urandom_range(0, 19) == 0) ? $urandom_range(P, 127) : $urandom_range(0, P - 1),
                          $urandom_range(0, 4) != 0, $urandom_range(0, 127), $urandom_range(0, 3));
            end
            run_proof($urandom_range(0, P - 1), $urandom_range(0, 4) == 0, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("r_queue_drained", exp_r_q.size(), 0);
        chk("verdict_queue_drained", exp_v_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
